// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button conditioner: debounce and arbiter
// state encodings plus the default timing constants.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DEB_P = 2'd1,
        HELD  = 2'd2,
        DEB_R = 2'd3
    } deb_state_t;

    typedef enum logic [1:0] {
        A_IDLE  = 2'd0,
        A_PULSE = 2'd1,
        A_GAP   = 2'd2
    } arb_state_t;

    localparam int DEB_CYC_DEF   = 20;
    localparam int PULSE_CYC_DEF = 2;
    localparam int GAP_CYC_DEF   = 1;

    // One-hot of the highest set bit; zero when nothing is set.
    function automatic logic [7:0] hi_onehot(input logic [7:0] req);
        logic [7:0] g;
        g = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (req[i]) g = 8'(1) << i;
        end
        return g;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchroniser followed by a press/release debounce FSM.
// Emits the debounced level and a single-cycle request on each accepted press.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEB_CYC = DEB_CYC_DEF
) (
    input  logic clk_1kHz,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic req
);

    localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYC - 1);

    logic          meta;
    logic          sync;
    deb_state_t    state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk_1kHz) begin
        if (!rst_n) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
            req   <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
            req  <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync) begin
                        state <= DEB_P;
                        cnt   <= '0;
                    end
                end
                DEB_P: begin
                    if (!sync) begin
                        state <= IDLE;
                    end else if (cnt == CNT_MAX) begin
                        state <= HELD;
                        level <= 1'b1;
                        req   <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HELD: begin
                    if (!sync) begin
                        state <= DEB_R;
                        cnt   <= '0;
                    end
                end
                DEB_R: begin
                    // A bounce back high during release is not a new press.
                    if (sync) begin
                        state <= HELD;
                    end else if (cnt == CNT_MAX) begin
                        state <= IDLE;
                        level <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Eight-button conditioner: per-channel debounce, pending latch and a single pulse
// arbiter that serialises presses into one-hot, fixed-width pulses (highest index first).
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int DEB_CYC   = DEB_CYC_DEF,
    parameter int PULSE_CYC = PULSE_CYC_DEF,
    parameter int GAP_CYC   = GAP_CYC_DEF
) (
    input  logic       clk_1kHz,
    input  logic       rst_n,
    input  logic       sw6,
    input  logic [7:0] btn_in,
    output logic [7:0] btn_out,
    output logic [7:0] btn_level,
    output logic       busy
);

    localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYC - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_CYC - 1);

    logic [7:0] req;
    logic [7:0] pending;
    logic [7:0] grant;
    logic [7:0] tcnt;
    logic       slot;
    arb_state_t arb;

    for (genvar n = 0; n < 8; n++) begin : g_ch
        btn_debounce_ch #(.DEB_CYC(DEB_CYC)) u_ch (
            .clk_1kHz (clk_1kHz),
            .rst_n    (rst_n),
            .raw      (btn_in[n]),
            .level    (btn_level[n]),
            .req      (req[n])
        );
    end

    // The last gap cycle doubles as an arbitration slot so back-to-back pulses
    // are separated by exactly GAP_CYC low cycles.
    always_comb begin
        slot  = (arb == A_IDLE) || ((arb == A_GAP) && (tcnt == GAP_LAST));
        grant = slot ? hi_onehot(pending) : '0;
    end

    always_ff @(posedge clk_1kHz) begin
        if (!rst_n) begin
            arb     <= A_IDLE;
            tcnt    <= '0;
            btn_out <= '0;
            pending <= '0;
        end else begin
            pending <= sw6 ? ((pending & ~grant) | req) : '0;
            case (arb)
                A_PULSE: begin
                    if (tcnt == PULSE_LAST) begin
                        btn_out <= '0;
                        arb     <= A_GAP;
                        tcnt    <= '0;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                A_IDLE, A_GAP: begin
                    if (|grant) begin
                        btn_out <= grant;
                        arb     <= A_PULSE;
                        tcnt    <= '0;
                    end else if (arb == A_GAP) begin
                        if (tcnt == GAP_LAST) arb <= A_IDLE;
                        else                  tcnt <= tcnt + 8'd1;
                    end
                end
                default: arb <= A_IDLE;
            endcase
        end
    end

    assign busy = (arb != A_IDLE) || (|pending);

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus random button activity, all
// compared against a timing-level reference model of the conditioner.
module tb_btn_conditioner;

    localparam int DEB = 20;
    localparam int PUL = 2;
    localparam int GAP = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sw6 = 1'b1;
    logic [7:0] btn_in = '0;
    logic [7:0] btn_out;
    logic [7:0] btn_level;
    logic       busy;

    int passed = 0;
    int total  = 0;

    btn_conditioner #(.DEB_CYC(DEB), .PULSE_CYC(PUL), .GAP_CYC(GAP)) dut (
        .clk_1kHz  (clk),
        .rst_n     (rst_n),
        .sw6       (sw6),
        .btn_in    (btn_in),
        .btn_out   (btn_out),
        .btn_level (btn_level),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model: a level flips once the synchronised input has disagreed with it
    // for DEB+1 consecutive samples; a rising flip queues a pulse, pulses start no
    // earlier than PUL+GAP edges after the previous one, highest index first.
    int         cyc = 0;
    logic [7:0] m_s1 = '0, m_s2 = '0, m_level = '0, m_req = '0, m_pend = '0;
    logic [7:0] m_out = '0, m_cur = '0;
    logic       m_busy = 1'b0;
    int         run [8];
    int         next_free = 0, pulse_end = 0;

    always @(posedge clk) begin : model
        logic [7:0] g, nreq;
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_level = '0; m_req = '0; m_pend = '0;
            m_out = '0; m_cur = '0; m_busy = 1'b0;
            next_free = 0; pulse_end = 0;
            for (int i = 0; i < 8; i++) run[i] = 0;
        end else begin
            g = '0;
            if (cyc >= next_free && m_pend != 0) begin
                for (int i = 7; i >= 0; i--) begin
                    if (m_pend[i]) begin g[i] = 1'b1; break; end
                end
                m_cur     = g;
                pulse_end = cyc + PUL;
                next_free = cyc + PUL + GAP;
            end
            m_out = (cyc < pulse_end) ? m_cur : '0;
            nreq = '0;
            for (int i = 0; i < 8; i++) begin
                if (m_s2[i] != m_level[i]) run[i]++;
                else run[i] = 0;
                if (run[i] == DEB + 1) begin
                    m_level[i] = ~m_level[i];
                    run[i] = 0;
                    nreq[i] = m_level[i];
                end
            end
            m_pend = sw6 ? ((m_pend & ~g) | m_req) : '0;
            m_req  = nreq;
            m_s2   = m_s1;
            m_s1   = btn_in;
            m_busy = (cyc < next_free) || (m_pend != 0);
        end
        cyc++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic settle(input int n);
        btn_in = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; sw6 = 1'b1; btn_in = '0;
        repeat (3) @(negedge clk);
        total++;
        if (btn_out !== 8'h00 || btn_level !== 8'h00 || busy !== 1'b0)
            $display("FAIL reset_outputs: out=%h level=%h busy=%b required 00 00 0", btn_out, btn_level, busy);
        else passed++;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if ({btn_out, btn_level, busy} !== {m_out, m_level, m_busy})
                $display("FAIL reset_idle k=%0d: out=%h level=%h busy=%b required %h %h %b", k, btn_out, btn_level, busy, m_out, m_level, m_busy);
            else passed++;
        end
    endtask

    task automatic test_clean_press;
        int rise_k = -1, hi = 0, starts = 0;
        logic [7:0] prev = '0;
        btn_in = 8'h80;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            total++;
            if ({btn_out, btn_level, busy} !== {m_out, m_level, m_busy})
                $display("FAIL clean_model k=%0d: out=%h level=%h busy=%b required %h %h %b", k, btn_out, btn_level, busy, m_out, m_level, m_busy);
            else passed++;
            if (btn_level[7] && rise_k < 0) rise_k = k;
            if (btn_out == 8'h80) hi++;
            if (btn_out != 0 && prev == 0) starts++;
            prev = btn_out;
        end
        total++;
        if (rise_k !== 22) $display("FAIL clean_level_edge: got %0d required 22", rise_k);
        else passed++;
        total++;
        if (hi !== 2 || starts !== 1) $display("FAIL clean_pulse: width=%0d pulses=%0d required 2 1", hi, starts);
        else passed++;
        settle(40);
    endtask

    task automatic test_bounce;
        int starts = 0, hi = 0;
        logic [7:0] prev = '0;
        for (int k = 0; k < 80; k++) begin
            if (k < 30 && k % 3 == 0) btn_in[6] = (k % 6 == 0);
            else if (k == 30) btn_in[6] = 1'b1;
            @(negedge clk);
            total++;
            if ({btn_out, btn_level, busy} !== {m_out, m_level, m_busy})
                $display("FAIL bounce_model k=%0d: out=%h level=%h busy=%b required %h %h %b", k, btn_out, btn_level, busy, m_out, m_level, m_busy);
            else passed++;
            if (btn_out == 8'h40) hi++;
            if (btn_out != 0 && prev == 0) starts++;
            prev = btn_out;
        end
        total++;
        if (starts !== 1 || hi !== 2) $display("FAIL bounce_single_pulse: pulses=%0d width=%0d required 1 2", starts, hi);
        else passed++;
        settle(40);
    endtask

    task automatic test_simultaneous;
        logic [7:0] q[$];
        logic [7:0] exp_seq [12];
        int f = -1;
        exp_seq = '{8'h80, 8'h80, 8'h00, 8'h20, 8'h20, 8'h00, 8'h10, 8'h10, 8'h00, 8'h01, 8'h01, 8'h00};
        btn_in = 8'hB1;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            total++;
            if ({btn_out, btn_level, busy} !== {m_out, m_level, m_busy})
                $display("FAIL simul_model k=%0d: out=%h level=%h busy=%b required %h %h %b", k, btn_out, btn_level, busy, m_out, m_level, m_busy);
            else passed++;
            q.push_back(btn_out);
        end
        for (int i = 0; i < q.size(); i++) begin
            if (q[i] != 0) begin f = i; break; end
        end
        total++;
        if (f < 0 || f + 12 > q.size()) begin
            $display("FAIL simul_start: first pulse index %0d, required a full sequence", f);
        end else begin
            passed++;
            for (int i = 0; i < 12; i++) begin
                total++;
                if (q[f+i] !== exp_seq[i]) $display("FAIL simul_seq[%0d]: got %h required %h", i, q[f+i], exp_seq[i]);
                else passed++;
            end
        end
        settle(40);
    endtask

    task automatic test_release_glitch;
        int starts = 0;
        logic [7:0] prev = '0;
        btn_in[4] = 1'b1;
        repeat (40) @(negedge clk);
        prev = btn_out;
        for (int k = 0; k < 45; k++) begin
            btn_in[4] = !(k < 5);
            @(negedge clk);
            total++;
            if ({btn_out, btn_level, busy} !== {m_out, m_level, m_busy})
                $display("FAIL glitch_model k=%0d: out=%h level=%h busy=%b required %h %h %b", k, btn_out, btn_level, busy, m_out, m_level, m_busy);
            else passed++;
            total++;
            if (btn_level[4] !== 1'b1) $display("FAIL glitch_level k=%0d: got %b required 1", k, btn_level[4]);
            else passed++;
            if (btn_out != 0 && prev == 0) starts++;
            prev = btn_out;
        end
        total++;
        if (starts !== 0) $display("FAIL glitch_no_pulse: pulses=%0d required 0", starts);
        else passed++;
        settle(40);
    endtask

    task automatic test_enable;
        sw6 = 1'b0;
        btn_in[5] = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (k == 30) sw6 = 1'b1;
            @(negedge clk);
            total++;
            if (btn_out !== 8'h00 || (k < 30 && busy !== 1'b0))
                $display("FAIL enable_suppress k=%0d: out=%h busy=%b required 00 0", k, btn_out, busy);
            else passed++;
            total++;
            if ({btn_out, btn_level, busy} !== {m_out, m_level, m_busy})
                $display("FAIL enable_model k=%0d: out=%h level=%h busy=%b required %h %h %b", k, btn_out, btn_level, busy, m_out, m_level, m_busy);
            else passed++;
        end
        total++;
        if (btn_level[5] !== 1'b1) $display("FAIL enable_level: got %b required 1", btn_level[5]);
        else passed++;
        settle(40);
    endtask

    task automatic test_reset_mid_pulse;
        int seen = -1, again = -1;
        btn_in[7] = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (btn_out == 8'h80) begin seen = k; break; end
        end
        total++;
        if (seen < 0) begin
            $display("FAIL midreset_first_pulse: got no pulse within 60 cycles, required 80");
        end else begin
            passed++;
            rst_n = 1'b0;
            @(negedge clk);
            total++;
            if (btn_out !== 8'h00 || btn_level !== 8'h00 || busy !== 1'b0)
                $display("FAIL midreset_clear: out=%h level=%h busy=%b required 00 00 0", btn_out, btn_level, busy);
            else passed++;
            rst_n = 1'b1;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                total++;
                if ({btn_out, btn_level, busy} !== {m_out, m_level, m_busy})
                    $display("FAIL midreset_model k=%0d: out=%h level=%h busy=%b required %h %h %b", k, btn_out, btn_level, busy, m_out, m_level, m_busy);
                else passed++;
                if (btn_out == 8'h80 && again < 0) again = k;
            end
            total++;
            if (again !== 24) $display("FAIL midreset_repulse_edge: got %0d required 24", again);
            else passed++;
        end
        settle(40);
    endtask

    task automatic test_random;
        int hold [8];
        for (int i = 0; i < 8; i++) hold[i] = $urandom_range(1, 40);
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < 8; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    btn_in[i] = ~btn_in[i];
                    hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(20, 60);
                end
            end
            if ($urandom_range(0, 199) == 0) sw6 = ~sw6;
            @(negedge clk);
            total++;
            if ({btn_out, btn_level, busy} !== {m_out, m_level, m_busy})
                $display("FAIL random_model k=%0d: out=%h level=%h busy=%b required %h %h %b", k, btn_out, btn_level, busy, m_out, m_level, m_busy);
            else passed++;
            total++;
            if ($countones(btn_out) > 1) $display("FAIL random_onehot k=%0d: out=%h required at most one bit", k, btn_out);
            else passed++;
        end
        sw6 = 1'b1;
        settle(40);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_release_glitch();
        test_enable();
        test_reset_mid_pulse();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
